// File: rtl/pipeline_controller_if.sv
// Handshake bundle between the pipeline datapath and its hazard/stall controller.
interface pipeline_controller_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             mem_dren;
   logic             mem_dwen;
   logic             halt_req;
   logic             ex_redirect;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             halt;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: reports pipeline status, consumes enables and flushes.
   modport master (
      output ihit, dhit, mem_dren, mem_dwen, halt_req, ex_redirect,
             ex_memread, ex_rt, id_rs, id_rt, id_uses_rt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halt, state, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  ihit, dhit, mem_dren, mem_dwen, halt_req, ex_redirect,
             ex_memread, ex_rt, id_rs, id_rt, id_uses_rt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, halt, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_controller.sv
// Five-stage pipeline hazard controller: memory freeze, redirect squash,
// load-use stall, fetch miss bubble and halt, with saturating event counters.
module pipeline_controller #(
   parameter int CNT_W = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_controller_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DWAIT   = 2'd1,
      LUSTALL = 2'd2,
      HALTED  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             halt_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   logic             freeze;
   logic             loaduse;
   logic             sel_redirect;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   assign freeze  = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;
   // A load into $0 never produces a value, so it cannot create a hazard.
   assign loaduse = bus.ex_memread & (bus.ex_rt != 5'd0) &
                    ((bus.ex_rt == bus.id_rs) |
                     (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

   // State register: control state, halt flag and event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         halt_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         halt_q  <= (state_d == HALTED);
         if (state_q != HALTED && !pc_en) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (sel_redirect)                flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   // Next-state: same transition function from every non-halted state.
   always_comb begin
      state_d = state_q;
      if (state_q != HALTED) begin
         if (bus.halt_req)                    state_d = HALTED;
         else if (freeze)                     state_d = DWAIT;
         else if (loaduse && !bus.ex_redirect) state_d = LUSTALL;
         else                                 state_d = RUN;
      end
   end

   // Output decode: priority halt_req > freeze > redirect > loaduse > fetch miss.
   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      sel_redirect = 1'b0;
      if (!rst && state_q != HALTED) begin
         if (bus.halt_req) begin
            // Let the halt instruction retire; everything behind it stops.
            memwb_en = 1'b1;
         end else if (freeze) begin
            // Whole pipe holds until the data access completes.
         end else if (bus.ex_redirect) begin
            sel_redirect = 1'b1;
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exmem_en     = 1'b1;
            memwb_en     = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
         end else if (loaduse) begin
            // Hold PC and IF/ID, inject a bubble into EX.
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (!bus.ihit) begin
            // Hold PC, push a bubble into ID while the fetch finishes.
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.ifid_en    = ifid_en;
   assign bus.idex_en    = idex_en;
   assign bus.exmem_en   = exmem_en;
   assign bus.memwb_en   = memwb_en;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_flush = idex_flush;
   assign bus.halt       = halt_q;
   assign bus.state      = state_q;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (counter width 4 to reach saturation).
module tb_pipeline_controller;

   localparam int CW = 4;

   // Output vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
   localparam logic [6:0] O_NONE   = 7'b0000000;
   localparam logic [6:0] O_NORM   = 7'b1111100;
   localparam logic [6:0] O_HALTRQ = 7'b0000100;
   localparam logic [6:0] O_REDIR  = 7'b1111111;
   localparam logic [6:0] O_LU     = 7'b0011101;
   localparam logic [6:0] O_MISS   = 7'b0111110;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipeline_controller_if #(.CNT_W(CW)) bus ();

   pipeline_controller #(.CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
              bus.ifid_flush, bus.idex_flush};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ihit        = 1'b1;
      bus.dhit        = 1'b0;
      bus.mem_dren    = 1'b0;
      bus.mem_dwen    = 1'b0;
      bus.halt_req    = 1'b0;
      bus.ex_redirect = 1'b0;
      bus.ex_memread  = 1'b0;
      bus.ex_rt       = 5'd0;
      bus.id_rs       = 5'd0;
      bus.id_rt       = 5'd0;
      bus.id_uses_rt  = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle_inputs();
      rst = 1'b1;
      bus.ex_redirect = 1'b1;
      #1;
      chk("reset_outs", {25'd0, outs()}, {25'd0, O_NONE});
      tick();
      tick();
      chk("reset_state", {30'd0, bus.state}, 32'd0);
      chk("reset_halt", {31'd0, bus.halt}, 32'd0);
      chk("reset_stall", {28'd0, bus.stall_cnt}, 32'd0);
      chk("reset_flush", {28'd0, bus.flush_cnt}, 32'd0);
      rst = 1'b0;
      idle_inputs();
      #1;

      // Normal cycle
      chk("normal_outs", {25'd0, outs()}, {25'd0, O_NORM});
      tick();
      chk("normal_state", {30'd0, bus.state}, 32'd0);

      // Load-use on rs
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      #1;
      chk("lu_rs_outs", {25'd0, outs()}, {25'd0, O_LU});
      tick();
      chk("lu_rs_state", {30'd0, bus.state}, 32'd2);
      chk("lu_rs_stall", {28'd0, bus.stall_cnt}, 32'd1);
      bus.ex_memread = 1'b0;
      #1;
      chk("lu_bubble_outs", {25'd0, outs()}, {25'd0, O_NORM});
      tick();
      chk("lu_bubble_state", {30'd0, bus.state}, 32'd0);

      // Load-use on rt: only a hazard when ID actually reads rt
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7;
      bus.id_uses_rt = 1'b0;
      #1;
      chk("rt_unused_outs", {25'd0, outs()}, {25'd0, O_NORM});
      bus.id_uses_rt = 1'b1;
      #1;
      chk("lu_rt_outs", {25'd0, outs()}, {25'd0, O_LU});
      tick();
      chk("lu_rt_stall", {28'd0, bus.stall_cnt}, 32'd2);

      // Load to $0 is never a hazard
      idle_inputs();
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
      #1;
      chk("lu_zero_outs", {25'd0, outs()}, {25'd0, O_NORM});
      tick();
      chk("lu_zero_state", {30'd0, bus.state}, 32'd0);

      // Data wait for 3 cycles, then dhit
      idle_inputs();
      bus.mem_dren = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dwait_outs", {25'd0, outs()}, {25'd0, O_NONE});
         tick();
         chk("dwait_state", {30'd0, bus.state}, 32'd1);
      end
      chk("dwait_stall", {28'd0, bus.stall_cnt}, 32'd5);
      bus.dhit = 1'b1;
      #1;
      chk("dhit_outs", {25'd0, outs()}, {25'd0, O_NORM});
      tick();
      chk("dhit_state", {30'd0, bus.state}, 32'd0);

      // Redirect overrides a load-use match
      idle_inputs();
      bus.ex_redirect = 1'b1; bus.ex_memread = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9;
      #1;
      chk("redir_outs", {25'd0, outs()}, {25'd0, O_REDIR});
      tick();
      chk("redir_state", {30'd0, bus.state}, 32'd0);
      chk("redir_flush", {28'd0, bus.flush_cnt}, 32'd1);

      // Freeze outranks redirect; no flush counted
      idle_inputs();
      bus.ex_redirect = 1'b1; bus.mem_dwen = 1'b1;
      #1;
      chk("frz_over_redir", {25'd0, outs()}, {25'd0, O_NONE});
      tick();
      chk("frz_flush_hold", {28'd0, bus.flush_cnt}, 32'd1);
      chk("frz_stall", {28'd0, bus.stall_cnt}, 32'd6);

      // Fetch miss
      idle_inputs();
      bus.ihit = 1'b0;
      #1;
      chk("miss_outs", {25'd0, outs()}, {25'd0, O_MISS});
      tick();
      chk("miss_state", {30'd0, bus.state}, 32'd0);
      chk("miss_stall", {28'd0, bus.stall_cnt}, 32'd7);

      // Halt outranks freeze; HALTED is absorbing
      idle_inputs();
      bus.halt_req = 1'b1; bus.mem_dren = 1'b1; bus.ex_redirect = 1'b1;
      #1;
      chk("halt_req_outs", {25'd0, outs()}, {25'd0, O_HALTRQ});
      tick();
      chk("halt_flag", {31'd0, bus.halt}, 32'd1);
      chk("halt_state", {30'd0, bus.state}, 32'd3);
      chk("halt_stall", {28'd0, bus.stall_cnt}, 32'd8);
      idle_inputs();
      bus.ex_redirect = 1'b1; bus.ihit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("halted_outs", {25'd0, outs()}, {25'd0, O_NONE});
         tick();
         chk("halted_state", {30'd0, bus.state}, 32'd3);
      end
      chk("halted_stall_hold", {28'd0, bus.stall_cnt}, 32'd8);
      chk("halted_flush_hold", {28'd0, bus.flush_cnt}, 32'd1);
      chk("halted_flag_hold", {31'd0, bus.halt}, 32'd1);

      // One-cycle reset out of HALTED
      rst = 1'b1;
      #1;
      chk("rst_halted_outs", {25'd0, outs()}, {25'd0, O_NONE});
      tick();
      rst = 1'b0;
      idle_inputs();
      chk("rst_halt", {31'd0, bus.halt}, 32'd0);
      chk("rst_state", {30'd0, bus.state}, 32'd0);
      chk("rst_stall", {28'd0, bus.stall_cnt}, 32'd0);
      chk("rst_flush", {28'd0, bus.flush_cnt}, 32'd0);
      #1;
      chk("post_rst_outs", {25'd0, outs()}, {25'd0, O_NORM});

      // Stall counter saturation: 20 fetch misses
      bus.ihit = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("stall_sat", {28'd0, bus.stall_cnt}, 32'd15);

      // Flush counter saturation: 20 redirects
      idle_inputs();
      bus.ex_redirect = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("flush_sat", {28'd0, bus.flush_cnt}, 32'd15);

      // Reset mid data wait
      idle_inputs();
      bus.mem_dwen = 1'b1;
      tick();
      chk("dwait2_state", {30'd0, bus.state}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_dwait_state", {30'd0, bus.state}, 32'd0);
      chk("rst_dwait_stall", {28'd0, bus.stall_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 CLK  in  1  single clock; all state updates occur on the rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 ihit  in  1  instruction fetch complete this cycle.
REQ-005 dhit  in  1  data access in MEM complete this cycle.
REQ-006 mem_dren, mem_dwen  in  1 each  load or store occupying MEM.
REQ-007 halt_req  in  1  halt instruction occupying MEM.
REQ-008 ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-009 ex_memread  in  1  load occupying EX; ex_rt  in  5  its destination register.
REQ-010 id_rs, id_rt  in  5 each  ID source registers; id_uses_rt  in  1  ID reads rt.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
REQ-012 ifid_flush, idex_flush  out  1 each  when asserted with the matching enable, the register loads a bubble.
REQ-013 halt  out  1  registered; processor halted.
REQ-014 state  out  2  RUN=0, DWAIT=1, LUSTALL=2, HALTED=3.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  registered event counters.

Function
REQ-016 Define freeze = (mem_dren | mem_dwen) & !dhit.
REQ-017 Define loaduse = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-018 All enable and flush outputs shall be combinational from state and inputs; state, halt and the counters shall be registered.
REQ-019 In a non-HALTED state, outputs shall follow the first matching case in this priority order: halt_req, freeze, ex_redirect, loaduse, !ihit, normal.
REQ-020 halt_req cycle: memwb_en=1, all other enables 0, flushes 0.
REQ-021 freeze cycle: all enables 0, flushes 0.
REQ-022 ex_redirect cycle: all enables 1, ifid_flush=1, idex_flush=1.
REQ-023 loaduse cycle: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1, ifid_flush=0.
REQ-024 !ihit cycle: pc_en=0, ifid_en=1, ifid_flush=1, all other enables 1, idex_flush=0.
REQ-025 Normal cycle: all enables 1, flushes 0.
REQ-026 The next-state function shall be identical from RUN, DWAIT and LUSTALL:
  - halt_req -> HALTED
  - else freeze -> DWAIT
  - else loaduse & !ex_redirect -> LUSTALL
  - else -> RUN
REQ-027 ex_redirect shall override loaduse, so the squashed ID instruction never stalls.
REQ-028 HALTED shall be absorbing until reset: all enables 0, flushes 0, halt=1 from the cycle after the halt_req edge.
REQ-029 A load-use stall shall last exactly one cycle per hazard; the bubble in EX clears loaduse.
REQ-030 freeze shall hold the pipeline for an unbounded number of cycles until dhit; on the dhit cycle, the priority evaluation resumes with freeze=0.
REQ-031 stall_cnt shall increment by 1 in every non-HALTED, non-reset cycle with pc_en=0, and saturate at all-ones.
REQ-032 flush_cnt shall increment by 1 in every cycle where the ex_redirect case is selected, and saturate at all-ones.

Reset
REQ-033 While RST=1:
  - all enables 0 and flushes 0
  - on each edge: state<=RUN, halt<=0, stall_cnt<=0, flush_cnt<=0
REQ-034 Reset asserted in any state, including HALTED or DWAIT mid-wait, shall take effect at the next edge; normal operation resumes on the first cycle with RST=0.

Verification
REQ-035 Load-use: ex_memread=1, ex_rt=5, id_rs=5, ihit=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1; state=LUSTALL next cycle; stall_cnt=1.
REQ-036 Load-use onto $0: ex_memread=1, ex_rt=0, id_rs=0 -> normal cycle; state stays RUN.
REQ-037 Data wait: mem_dren=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles, state=DWAIT, stall_cnt=3; all enables 1 on the dhit cycle.
REQ-038 Redirect wins: ex_redirect=1 with a loaduse match -> all enables 1, both flushes 1; state RUN; flush_cnt=1.
REQ-039 Halt: halt_req=1 -> memwb_en=1 only; next cycle halt=1, state=3, all enables 0 held for 10 cycles; RST=1 for 1 cycle -> halt=0, state=0, counters 0.
REQ-040 Saturation: with CNT_W=4, 20 !ihit cycles -> stall_cnt=15.
